// File: rtl/ccff_bitstream_loader_if.sv
// Bitstream word handshake between a word source and the ccff loader.
// The source drives word_in/word_valid; the loader answers with word_ready.
interface ccff_bitstream_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_in,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_in,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words MSB first into a configuration flip-flop chain.
// Optional macro CCFF_TAIL_CHECK_EN prepends an 8'hA5 marker and checks it at ccff_tail.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 4096,
    parameter int WORD_W    = 32
) (
    input  logic                   prog_clk,
    input  logic                   prog_reset,
    input  logic                   start,
    ccff_bitstream_loader_if.slave wr,
    output logic                   ccff_head,
    output logic                   ccff_shift_en,
    input  logic                   ccff_tail,
    output logic                   config_enable,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

`ifdef CCFF_TAIL_CHECK_EN
    localparam int MK_LEN = 8;
    localparam logic [7:0] MARKER = 8'hA5;
`else
    localparam int MK_LEN = 0;
`endif
    localparam logic [16:0] TOTAL = 17'(CHAIN_LEN + MK_LEN);
    localparam int PW = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic [PW-1:0]     rem_q, rem_d;
    logic [16:0]       cnt_q, cnt_d;

    logic marker_ph;
    logic mk_bit;
    logic last_bit;
    logic shift;
    logic final_sh;
    logic ready;
    logic accept;

    // Marker phase covers the first MK_LEN shifts and draws no word bits.
`ifdef CCFF_TAIL_CHECK_EN
    assign marker_ph = cnt_q < 17'd8;
    assign mk_bit    = MARKER[3'd7 - cnt_q[2:0]];
`else
    assign marker_ph = 1'b0;
    assign mk_bit    = 1'b0;
`endif

    assign last_bit = !marker_ph && (rem_q == PW'(1));
    assign shift    = (state_q == LOAD) && (marker_ph || (rem_q != '0));
    assign final_sh = shift && ((cnt_q + 17'd1) == TOTAL);
    // No new word is taken on the final shift: none of its bits would be used.
    assign ready    = (state_q == LOAD) && ((rem_q == '0) || last_bit) && !final_sh;
    assign accept   = ready && wr.word_valid;

    assign wr.word_ready = ready;
    assign ccff_shift_en = shift;
    assign ccff_head     = shift && (marker_ph ? mk_bit : buf_q[WORD_W-1]);
    assign config_enable = state_q != IDLE;
    assign busy          = state_q != IDLE;
    assign done          = state_q == FINISH;

    // Next state, buffer refill/shift and shift counting.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    rem_d   = '0;
                end
            end
            LOAD: begin
                if (shift) begin
                    cnt_d = cnt_q + 17'd1;
                    if (!marker_ph) begin
                        buf_d = {buf_q[WORD_W-2:0], 1'b0};
                        rem_d = rem_q - PW'(1);
                    end
                end
                if (accept) begin
                    buf_d = wr.word_in;
                    rem_d = PW'(WORD_W);
                end
                if (final_sh) begin
                    state_d = FINISH;
                    buf_d   = '0;
                    rem_d   = '0;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state_q <= IDLE;
            buf_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef CCFF_TAIL_CHECK_EN
    logic       err_q, err_d;
    logic       shifted_q;
    logic [2:0] chk_idx;

    assign chk_idx = 3'(cnt_q - 17'(CHAIN_LEN));

    // Marker reappears at the tail after CHAIN_LEN shifts; any wrong bit is sticky.
    always_comb begin
        err_d = err_q;
        if ((state_q == IDLE) && start) begin
            err_d = 1'b0;
        end else if (shifted_q && (cnt_q >= 17'(CHAIN_LEN)) && (cnt_q < TOTAL)
                     && (ccff_tail != MARKER[3'd7 - chk_idx])) begin
            err_d = 1'b1;
        end
    end

    // Error flag and one-cycle-delayed shift marker for the tail compare.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            err_q     <= 1'b0;
            shifted_q <= 1'b0;
        end else begin
            err_q     <= err_d;
            shifted_q <= shift;
        end
    end

    assign err = err_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: 64- and 40-bit chains modelled as shift registers.
// Expected stream = optional marker followed by word bits, checked every cycle.
module tb_ccff_bitstream_loader;

`ifdef CCFF_TAIL_CHECK_EN
    localparam int MK = 8;
`else
    localparam int MK = 0;
`endif
    localparam int BASE = (MK == 0) ? 1 : 0;

    typedef struct {
        int          sel;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap;
        int          poke;
        logic [63:0] exp;
        int          stall;
        bit          inv;
    } vec_t;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic        prog_reset = 1'b1;
    logic        st = 1'b0;
    logic        inv = 1'b0;
    logic        sel = 1'b0;
    logic        w_vld = 1'b0;
    logic [31:0] w_in = '0;

    ccff_bitstream_loader_if #(.WORD_W(32)) if_a ();
    ccff_bitstream_loader_if #(.WORD_W(32)) if_b ();

    assign if_a.word_in    = w_in;
    assign if_b.word_in    = w_in;
    assign if_a.word_valid = w_vld && !sel;
    assign if_b.word_valid = w_vld && sel;

    logic start_a, start_b;
    assign start_a = st && !sel;
    assign start_b = st && sel;

    logic head_a, sh_a, cfg_a, bsy_a, dn_a, er_a, tail_a;
    logic head_b, sh_b, cfg_b, bsy_b, dn_b, er_b, tail_b;
    logic [63:0] chain_a = '0;
    logic [39:0] chain_b = '0;

    ccff_bitstream_loader #(.CHAIN_LEN(64), .WORD_W(32)) dut_a (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_a),
        .wr(if_a), .ccff_head(head_a), .ccff_shift_en(sh_a),
        .ccff_tail(tail_a), .config_enable(cfg_a), .busy(bsy_a),
        .done(dn_a), .err(er_a)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(40), .WORD_W(32)) dut_b (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start_b),
        .wr(if_b), .ccff_head(head_b), .ccff_shift_en(sh_b),
        .ccff_tail(tail_b), .config_enable(cfg_b), .busy(bsy_b),
        .done(dn_b), .err(er_b)
    );

    always @(posedge prog_clk) begin
        if (sh_a) chain_a <= {chain_a[62:0], head_a};
        if (sh_b) chain_b <= {chain_b[38:0], head_b};
    end

    assign tail_a = chain_a[63] ^ inv;
    assign tail_b = chain_b[39] ^ inv;

    logic rdy, head, shen, cfg, bsy, dn, er;
    assign rdy  = sel ? if_b.word_ready : if_a.word_ready;
    assign head = sel ? head_b : head_a;
    assign shen = sel ? sh_b : sh_a;
    assign cfg  = sel ? cfg_b : cfg_a;
    assign bsy  = sel ? bsy_b : bsy_a;
    assign dn   = sel ? dn_b : dn_a;
    assign er   = sel ? er_b : er_a;

    int total = 0;
    int bad = 0;
    logic [7:0]  mk_v = 8'hA5;
    logic [31:0] wv [3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_rdy"}, 64'(rdy), 64'd0);
        chk({nm, "_head"}, 64'(head), 64'd0);
        chk({nm, "_shen"}, 64'(shen), 64'd0);
        chk({nm, "_cfg"}, 64'(cfg), 64'd0);
        chk({nm, "_busy"}, 64'(bsy), 64'd0);
        chk({nm, "_done"}, 64'(dn), 64'd0);
        chk({nm, "_err"}, 64'(er), 64'd0);
    endtask

    function automatic logic sbit(input int s);
        int d;
        if (s < MK) return mk_v[7 - s];
        d = s - MK;
        return wv[d / 32][31 - (d % 32)];
    endfunction

    task automatic run_load(input vec_t v, input int pct, input int abort_at);
        int  n_len, tot, idx, deliv, cons, shifts, stalls, cyc, hold, av;
        bit  mk, sh_e, rdy_e, vld, err_e;
        n_len = (v.sel != 0) ? 40 : 64;
        tot = n_len + MK;
        sel = (v.sel != 0);
        inv = v.inv;
        wv[0] = v.w0;
        wv[1] = v.w1;
        wv[2] = 32'hFFFF_FFFF;
        idx = 0; deliv = 0; cons = 0; shifts = 0;
        stalls = 0; cyc = 0; hold = v.gap; err_e = 0;
        @(negedge prog_clk);
        w_in = 32'hCAFE_F00D;
        w_vld = 1'b1;
        #1 chk("idle_word_rdy", 64'(rdy), 64'd0);
        st = 1'b1;
        @(negedge prog_clk);
        st = 1'b0;
        while (shifts < tot && cyc < 2000) begin
            cyc++;
            if (shifts == abort_at) begin
                prog_reset = 1'b1;
                st = 1'b1;
                @(negedge prog_clk);
                #1 chk_zero("in_reset");
                prog_reset = 1'b0;
                st = 1'b0;
                w_vld = 1'b0;
                @(negedge prog_clk);
                #1 chk_zero("after_reset");
                return;
            end
            mk = shifts < MK;
            av = deliv - cons;
            sh_e = mk || av > 0;
            rdy_e = (av == 0 || (!mk && av == 1)) && !(sh_e && shifts + 1 == tot);
            if (idx >= 2) begin
                w_in = wv[2];
                vld = 1'b1;
            end else begin
                w_in = wv[idx];
                if (idx == 1 && hold > 0) begin
                    vld = 1'b0;
                    if (!mk && av <= 1) hold--;
                end else begin
                    vld = (pct >= 100) || ($urandom_range(99) < pct);
                end
            end
            w_vld = vld;
            st = (shifts == v.poke);
            #1;
            chk("shift_en", 64'(shen), 64'(sh_e));
            if (sh_e) chk("head", 64'(head), 64'(sbit(shifts)));
            chk("ready", 64'(rdy), 64'(rdy_e));
            chk("load_cfg", 64'(cfg), 64'd1);
            chk("load_busy", 64'(bsy), 64'd1);
            chk("load_done", 64'(dn), 64'd0);
            chk("load_err", 64'(er), 64'(err_e));
            if (!sh_e) stalls++;
            @(posedge prog_clk);
            if (MK != 0 && v.inv && shifts == n_len) err_e = 1'b1;
            if (vld && rdy_e) begin
                deliv += 32;
                idx++;
            end
            if (sh_e) begin
                shifts++;
                if (!mk) cons++;
            end
            @(negedge prog_clk);
        end
        st = 1'b0;
        if (cyc >= 2000) begin
            total++;
            bad++;
            $display("FAIL timeout shifts=%0d need=%0d", shifts, tot);
        end
        w_in = wv[2];
        w_vld = 1'b1;
        #1;
        chk("fin_done", 64'(dn), 64'd1);
        chk("fin_cfg", 64'(cfg), 64'd1);
        chk("fin_busy", 64'(bsy), 64'd1);
        chk("fin_rdy", 64'(rdy), 64'd0);
        chk("fin_shen", 64'(shen), 64'd0);
        @(negedge prog_clk);
        #1;
        chk("idle_done", 64'(dn), 64'd0);
        chk("idle_cfg", 64'(cfg), 64'd0);
        chk("idle_busy", 64'(bsy), 64'd0);
        chk("idle_rdy", 64'(rdy), 64'd0);
        chk("err_sticky", 64'(er), 64'(err_e));
        chk("chain", sel ? {24'd0, chain_b} : chain_a, v.exp);
        if (v.stall >= 0) chk("stalls", 64'(stalls), 64'(v.stall));
        w_vld = 1'b0;
    endtask

    vec_t vt [6];
    vec_t r;

    initial begin
        vt[0] = '{0, 32'hDEADBEEF, 32'h12345678, 0, -1,
                  64'hDEADBEEF12345678, BASE, 1'b0};
        vt[1] = '{0, 32'hDEADBEEF, 32'h12345678, 5, -1,
                  64'hDEADBEEF12345678, BASE + 5, 1'b0};
        vt[2] = '{1, 32'hDEADBEEF, 32'h12345678, 0, -1,
                  64'h000000DEADBEEF12, BASE, 1'b0};
        vt[3] = '{0, 32'hA5A50F0F, 32'h0123CDEF, 0, 10,
                  64'hA5A50F0F0123CDEF, BASE, 1'b0};
        vt[4] = '{0, 32'h80000001, 32'h7FFFFFFE, 0, -1,
                  64'h800000017FFFFFFE, BASE, 1'b1};
        vt[5] = '{0, 32'h13579BDF, 32'h2468ACE0, 0, -1,
                  64'h13579BDF2468ACE0, BASE, 1'b0};

        st = 1'b1;
        repeat (3) @(negedge prog_clk);
        #1 chk_zero("reset_state");
        chk("reset_rdy_b", 64'(if_b.word_ready), 64'd0);
        prog_reset = 1'b0;
        st = 1'b0;
        @(negedge prog_clk);
        #1 chk_zero("post_reset");

        for (int i = 0; i < 6; i++) run_load(vt[i], 100, -1);

        run_load(vt[0], 100, 20);
        run_load(vt[5], 100, -1);

        for (int i = 0; i < 6; i++) begin
            r.sel = int'($urandom_range(1));
            r.w0 = $urandom;
            r.w1 = $urandom;
            r.gap = 0;
            r.poke = int'($urandom_range(40));
            r.stall = -1;
            r.inv = 1'($urandom_range(1));
            if (r.sel != 0) r.exp = {24'd0, r.w0, r.w1[31:24]};
            else r.exp = {r.w0, r.w1};
            run_load(r, 60, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
